// File: rtl/reg_file_sb_if.sv
// Register-file/scoreboard bus: write port, two read ports, issue port and status.
interface reg_file_sb_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic [WIDTH-1:0] din;
  logic [AW-1:0]    wr_addr;
  logic             wr_E;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic             iss_E;
  logic [AW-1:0]    iss_addr;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             busy_a;
  logic             busy_b;
  logic             stall;
  logic [AW:0]      pend_cnt;

  modport master (
    output din, wr_addr, wr_E, rd_addr_a, rd_addr_b, iss_E, iss_addr,
    input  out_a, out_b, busy_a, busy_b, stall, pend_cnt
  );
  modport slave (
    input  din, wr_addr, wr_E, rd_addr_a, rd_addr_b, iss_E, iss_addr,
    output out_a, out_b, busy_a, busy_b, stall, pend_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard, optional write-through bypass
// and optional hardwired-zero register 0.
module reg_file_sb_rdport #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs_i,
  input  logic [DEPTH-1:0]            busy_i,
  input  logic [AW-1:0]               rd_addr_i,
  input  logic [AW-1:0]               wr_addr_i,
  input  logic                        wr_e_i,
  input  logic [WIDTH-1:0]            din_i,
  output logic [WIDTH-1:0]            data_o,
  output logic                        busy_o
);
  logic zero_hit, fwd;

  assign zero_hit = (ZERO_REG != 0) && (rd_addr_i == '0);
  assign fwd      = (BYPASS != 0) && wr_e_i && (wr_addr_i == rd_addr_i);

  always_comb begin
    data_o = regs_i[rd_addr_i];
    if (zero_hit)  data_o = '0;
    else if (fwd)  data_o = din_i;
  end

  // A forwarded write resolves the pending producer in the same cycle.
  assign busy_o = busy_i[rd_addr_i] && !zero_hit && !fwd;
endmodule

module reg_file_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic         CLK,
  input logic         CLR,
  reg_file_sb_if.slave bus
);
  logic [DEPTH-1:0][WIDTH-1:0] regs_q;
  logic [DEPTH-1:0]            busy_q, busy_d;
  logic [AW:0]                 pend_q, pend_d;
  logic                        wr_ok, stall, iss_set;
  logic [1:0][AW-1:0]          rd_addr;
  logic [1:0][WIDTH-1:0]       rd_data;
  logic [1:0]                  rd_busy;

  assign wr_ok   = bus.wr_E && !((ZERO_REG != 0) && (bus.wr_addr == '0));
  // WAW hazard only if the same-cycle writeback does not retire the old producer.
  assign stall   = bus.iss_E && busy_q[bus.iss_addr] &&
                   !(bus.wr_E && (bus.wr_addr == bus.iss_addr));
  assign iss_set = bus.iss_E && !stall && !((ZERO_REG != 0) && (bus.iss_addr == '0));

  always_comb begin
    busy_d = busy_q;
    if (bus.wr_E) busy_d[bus.wr_addr]  = 1'b0;
    if (iss_set)  busy_d[bus.iss_addr] = 1'b1;
  end

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < DEPTH; i++) pend_d = pend_d + {{AW{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      regs_q <= '0;
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      if (wr_ok) regs_q[bus.wr_addr] <= bus.din;
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  assign rd_addr = {bus.rd_addr_b, bus.rd_addr_a};

  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd
      reg_file_sb_rdport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
      ) u_rd (
        .regs_i   (regs_q),
        .busy_i   (busy_q),
        .rd_addr_i(rd_addr[p]),
        .wr_addr_i(bus.wr_addr),
        .wr_e_i   (bus.wr_E),
        .din_i    (bus.din),
        .data_o   (rd_data[p]),
        .busy_o   (rd_busy[p])
      );
    end
  endgenerate

  assign bus.out_a    = rd_data[0];
  assign bus.out_b    = rd_data[1];
  assign bus.busy_a   = rd_busy[0];
  assign bus.busy_b   = rd_busy[1];
  assign bus.stall    = stall;
  assign bus.pend_cnt = pend_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: three instances (defaults, ZERO_REG=1, BYPASS=0) share one stimulus.
`timescale 1ns/1ps
module tb_reg_file_sb;
  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic [15:0] din = '0;
  logic [2:0]  wr_addr = '0, rd_a = '0, rd_b = '0, iss_addr = '0;
  logic        wr_E = 1'b0, iss_E = 1'b0;
  int          n_cmp = 0, n_bad = 0;

  always #5 CLK = ~CLK;

  reg_file_sb_if #(.WIDTH(16), .AW(3)) b0 ();
  reg_file_sb_if #(.WIDTH(16), .AW(3)) b1 ();
  reg_file_sb_if #(.WIDTH(16), .AW(3)) b2 ();

  assign b0.din = din;  assign b0.wr_addr = wr_addr;  assign b0.wr_E = wr_E;
  assign b0.rd_addr_a = rd_a;  assign b0.rd_addr_b = rd_b;
  assign b0.iss_E = iss_E;  assign b0.iss_addr = iss_addr;
  assign b1.din = din;  assign b1.wr_addr = wr_addr;  assign b1.wr_E = wr_E;
  assign b1.rd_addr_a = rd_a;  assign b1.rd_addr_b = rd_b;
  assign b1.iss_E = iss_E;  assign b1.iss_addr = iss_addr;
  assign b2.din = din;  assign b2.wr_addr = wr_addr;  assign b2.wr_E = wr_E;
  assign b2.rd_addr_a = rd_a;  assign b2.rd_addr_b = rd_b;
  assign b2.iss_E = iss_E;  assign b2.iss_addr = iss_addr;

  reg_file_sb                                   dut   (.CLK(CLK), .CLR(CLR), .bus(b0));
  reg_file_sb #(.ZERO_REG(1))                   dut_z (.CLK(CLK), .CLR(CLR), .bus(b1));
  reg_file_sb #(.BYPASS(0))                     dut_n (.CLK(CLK), .CLR(CLR), .bus(b2));

  typedef struct {
    logic        we;  logic [2:0] wa; logic [15:0] d;
    logic [2:0]  ra;  logic [2:0] rb;
    logic        ie;  logic [2:0] ia;
    logic [15:0] ea;  logic [15:0] eb;
    logic        eba; logic ebb; logic est;
    logic [3:0]  ep;
  } vec_t;
  vec_t tv [14];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic drv(input logic we, input logic [2:0] wa, input logic [15:0] d,
                     input logic [2:0] ra, input logic [2:0] rb,
                     input logic ie, input logic [2:0] ia);
    wr_E = we; wr_addr = wa; din = d; rd_a = ra; rd_b = rb; iss_E = ie; iss_addr = ia;
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  initial begin
    //        we wa d         ra rb ie ia  ea        eb        eba  ebb  est  ep
    tv[0]  = '{0, 0, 16'h0,    3, 0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0};
    tv[1]  = '{1, 3, 16'h1234, 3, 1, 0, 0, 16'h1234, 16'h0,    0, 0, 0, 0};
    tv[2]  = '{0, 0, 16'h0,    3, 3, 0, 0, 16'h1234, 16'h1234, 0, 0, 0, 0};
    tv[3]  = '{1, 5, 16'hBEEF, 3, 5, 0, 0, 16'h1234, 16'hBEEF, 0, 0, 0, 0};
    tv[4]  = '{0, 0, 16'h0,    2, 5, 1, 2, 16'h0,    16'hBEEF, 0, 0, 0, 0};
    tv[5]  = '{0, 0, 16'h0,    2, 2, 1, 2, 16'h0,    16'h0,    1, 1, 1, 1};
    tv[6]  = '{1, 2, 16'h00AA, 2, 3, 0, 0, 16'h00AA, 16'h1234, 0, 0, 0, 1};
    tv[7]  = '{0, 0, 16'h0,    2, 5, 0, 0, 16'h00AA, 16'hBEEF, 0, 0, 0, 0};
    tv[8]  = '{0, 0, 16'h0,    4, 4, 1, 4, 16'h0,    16'h0,    0, 0, 0, 0};
    tv[9]  = '{1, 4, 16'h4444, 4, 0, 1, 4, 16'h4444, 16'h0,    0, 0, 0, 1};
    tv[10] = '{0, 0, 16'h0,    4, 4, 0, 0, 16'h4444, 16'h4444, 1, 1, 0, 1};
    tv[11] = '{0, 0, 16'h0,    4, 3, 1, 4, 16'h4444, 16'h1234, 1, 0, 1, 1};
    tv[12] = '{1, 5, 16'h5555, 4, 5, 0, 0, 16'h4444, 16'h5555, 1, 0, 0, 1};
    tv[13] = '{0, 0, 16'h0,    5, 4, 0, 0, 16'h5555, 16'h4444, 0, 1, 0, 1};

    // Reset state
    drv(0, 0, 0, 3, 5, 1, 3);
    @(negedge CLK);
    chk("rst_pend",  b0.pend_cnt, 0);
    chk("rst_out_a", b0.out_a, 0);
    chk("rst_stall", b0.stall, 0);
    chk("rst_z_pend", b1.pend_cnt, 0);
    chk("rst_n_out_b", b2.out_b, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0);
    CLR = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drv(tv[i].we, tv[i].wa, tv[i].d, tv[i].ra, tv[i].rb, tv[i].ie, tv[i].ia);
      @(negedge CLK);
      chk($sformatf("v%0d_out_a", i),  b0.out_a,    tv[i].ea);
      chk($sformatf("v%0d_out_b", i),  b0.out_b,    tv[i].eb);
      chk($sformatf("v%0d_busy_a", i), b0.busy_a,   tv[i].eba);
      chk($sformatf("v%0d_busy_b", i), b0.busy_b,   tv[i].ebb);
      chk($sformatf("v%0d_stall", i),  b0.stall,    tv[i].est);
      chk($sformatf("v%0d_pend", i),   b0.pend_cnt, tv[i].ep);
      if (i == 1) chk("nobyp_same_cycle_old", b2.out_a, 16'h0);
      if (i == 2) chk("nobyp_next_cycle", b2.out_a, 16'h1234);
      tick;
    end

    // Fill the scoreboard; r4 is already pending so its issue stalls
    for (int i = 0; i < 8; i++) begin
      drv(0, 0, 0, 0, 0, 1, 3'(i));
      @(negedge CLK);
      chk($sformatf("full_stall_r%0d", i), b0.stall, (i == 4));
      tick;
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("full_pend",   b0.pend_cnt, 8);
    chk("full_z_pend", b1.pend_cnt, 7);
    chk("full_n_pend", b2.pend_cnt, 8);
    chk("z_busy_r0",   b1.busy_a, 0);
    chk("busy_r0",     b0.busy_a, 1);
    tick;

    // Write 0xFFFF to r0
    drv(1, 0, 16'hFFFF, 0, 0, 0, 0);
    @(negedge CLK);
    chk("z_wr0_same_out", b1.out_a, 0);
    chk("wr0_bypass_out", b0.out_a, 16'hFFFF);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("z_rd0_out",  b1.out_a, 0);
    chk("z_rd0_busy", b1.busy_a, 0);
    chk("rd0_out",    b0.out_a, 16'hFFFF);
    chk("rd0_pend",   b0.pend_cnt, 7);
    chk("z_rd0_pend", b1.pend_cnt, 7);
    tick;

    // Writeback to busy r6: bypass vs. no bypass
    drv(1, 6, 16'h6666, 6, 0, 0, 0);
    @(negedge CLK);
    chk("n_wr6_same_out",  b2.out_a, 0);
    chk("n_wr6_same_busy", b2.busy_a, 1);
    chk("wr6_same_out",    b0.out_a, 16'h6666);
    chk("wr6_same_busy",   b0.busy_a, 0);
    tick;
    drv(0, 0, 0, 6, 0, 0, 0);
    @(negedge CLK);
    chk("n_rd6_out",  b2.out_a, 16'h6666);
    chk("n_rd6_busy", b2.busy_a, 0);
    chk("rd6_pend",   b0.pend_cnt, 6);
    chk("z_rd6_pend", b1.pend_cnt, 6);
    tick;

    // Mid-operation reset with three pending registers
    CLR = 1'b0; #2; CLR = 1'b1;
    drv(1, 7, 16'h7777, 0, 0, 1, 1); tick;
    drv(0, 0, 0, 0, 0, 1, 2); tick;
    drv(0, 0, 0, 0, 0, 1, 3); tick;
    drv(0, 0, 0, 1, 7, 0, 0);
    @(negedge CLK);
    chk("pre_rst_pend",   b0.pend_cnt, 3);
    chk("pre_rst_busy_a", b0.busy_a, 1);
    chk("pre_rst_out_b",  b0.out_b, 16'h7777);
    tick;
    CLR = 1'b0;
    drv(0, 0, 0, 7, 1, 1, 1);
    #1;
    chk("async_rst_pend",   b0.pend_cnt, 0);
    chk("async_rst_out_a",  b0.out_a, 0);
    chk("async_rst_busy_b", b0.busy_b, 0);
    chk("async_rst_stall",  b0.stall, 0);
    drv(1, 5, 16'h5555, 0, 0, 0, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      rd_a = 3'(i);
      #1;
      chk($sformatf("rst_data_r%0d", i), b0.out_a, 0);
    end
    drv(0, 0, 0, 0, 0, 1, 6);
    CLR = 1'b1;
    tick;
    drv(0, 0, 0, 6, 5, 0, 0);
    @(negedge CLK);
    chk("post_rst_pend",   b0.pend_cnt, 1);
    chk("post_rst_busy_a", b0.busy_a, 1);
    chk("post_rst_wr_ign", b0.out_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
